// File: rtl/pm_pkg.sv
// Shared definitions for the serial-parallel multiplier family:
// controller states, size limits and the run-counter width helper.
package pm_pkg;

    localparam int MAX_SIZE = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int cntWidth(input int size);
        return $clog2(2 * size + 1);
    endfunction

endpackage

// File: rtl/spm_core.sv
// Bit-serial carry-save multiplier array: parallel x, serial y (LSB first),
// one product bit per cycle on p, LSB first.
module spm_core #(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [SIZE-1:0] x,
    input  logic            y,
    output logic            p
);

    logic [SIZE-1:0] sum_q, sum_d;
    logic [SIZE-1:0] carry_q, carry_d;
    logic [SIZE-1:0] partialProd;
    logic [SIZE-1:0] cellSum;
    logic [SIZE-1:0] cellCarry;

    // Each cell adds its partial-product bit to its held sum and carry. Cell 0's
    // sum leaves as the product bit; the sums move down one cell (the frame
    // halves) while each carry stays in its cell, now at the right weight.
    always_comb begin
        partialProd = y ? x : '0;
        cellSum     = partialProd ^ sum_q ^ carry_q;
        cellCarry   = (partialProd & sum_q) | (partialProd & carry_q) | (sum_q & carry_q);
        sum_d       = {1'b0, cellSum[SIZE-1:1]};
        carry_d     = cellCarry;
        p           = cellSum[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else if (clr) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: rtl/spm_mul_hs.sv
// Serial-parallel multiplier with valid/ready handshake, signed mode and abort.
// Operands are reduced to magnitudes, multiplied bit-serially, then negated if needed.
module spm_mul_hs
    import pm_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = cntWidth(SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              signed_mode,
    input  logic [SIZE-1:0]   mc,
    input  logic [SIZE-1:0]   mp,
    input  logic              abort,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] p,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(2 * SIZE - 1);
    localparam logic [SIZE-1:0]   OP_ONE   = SIZE'(1);
    localparam logic [2*SIZE-1:0] P_ONE    = (2 * SIZE)'(1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   mc_q, mc_d;
    logic [SIZE-1:0]   mp_q, mp_d;
    logic              neg_q, neg_d;
    logic [2*SIZE-1:0] p_q, p_d;

    logic              accept;
    logic              coreClr;
    logic              coreY;
    logic              coreP;
    logic [SIZE-1:0]   mcAbs;
    logic [SIZE-1:0]   mpAbs;

    assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept    = in_valid && in_ready && !abort;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN) || (state_q == FIX);
    assign p         = p_q;

    // The most negative operand maps to 2^(SIZE-1), which still fits unsigned.
    assign mcAbs = (signed_mode && mc[SIZE-1]) ? (~mc + OP_ONE) : mc;
    assign mpAbs = (signed_mode && mp[SIZE-1]) ? (~mp + OP_ONE) : mp;

    // The core sees zeros outside RUN, so it idles at its cleared state.
    assign coreY = (state_q == RUN) && mp_q[0];

    spm_core #(
        .SIZE (SIZE)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .clr (coreClr),
        .x   (mc_q),
        .y   (coreY),
        .p   (coreP)
    );

    // Abort wins over everything; an accept in DONE reloads straight into RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        neg_d   = neg_q;
        p_d     = p_q;
        coreClr = 1'b0;

        if (abort) begin
            state_d = IDLE;
            coreClr = 1'b1;
        end else if (accept) begin
            state_d = RUN;
            cnt_d   = '0;
            mc_d    = mcAbs;
            mp_d    = mpAbs;
            neg_d   = signed_mode && (mc[SIZE-1] ^ mp[SIZE-1]);
            p_d     = '0;
            coreClr = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                RUN: begin
                    mp_d  = {1'b0, mp_q[SIZE-1:1]};
                    p_d   = {coreP, p_q[2*SIZE-1:1]};
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = FIX;
                    end
                end
                FIX: begin
                    if (neg_q) begin
                        p_d = ~p_q + P_ONE;
                    end
                    state_d = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mc_q    <= '0;
            mp_q    <= '0;
            neg_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            neg_q   <= neg_d;
            p_q     <= p_d;
        end
    end

endmodule

// File: tb/tb_spm_mul_hs.sv
// Directed bench for spm_mul_hs: an 8-bit instance for handshake, latency, abort
// and reset cases, plus a 32-bit instance swept against a multiply reference.
module tb_spm_mul_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, signed_mode, abort;
    logic        out_valid, out_ready, busy;
    logic [7:0]  mc, mp;
    logic [15:0] p;

    logic        in_valid32, in_ready32, signed_mode32, abort32;
    logic        out_valid32, out_ready32, busy32;
    logic [31:0] mc32, mp32;
    logic [63:0] p32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spm_mul_hs #(.SIZE(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .signed_mode (signed_mode),
        .mc          (mc),
        .mp          (mp),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .p           (p),
        .busy        (busy)
    );

    spm_mul_hs #(.SIZE(32)) dut32 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid32),
        .in_ready    (in_ready32),
        .signed_mode (signed_mode32),
        .mc          (mc32),
        .mp          (mp32),
        .abort       (abort32),
        .out_valid   (out_valid32),
        .out_ready   (out_ready32),
        .p           (p32),
        .busy        (busy32)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands and hold in_valid until the accept edge has passed.
    task automatic applyStimulus(input logic sm, input logic [7:0] a, input logic [7:0] b);
        int guard = 0;
        signed_mode = sm;
        mc          = a;
        mp          = b;
        in_valid    = 1'b1;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        checkOutput("accept_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int edges);
        edges = 0;
        while (!out_valid && edges < 200) begin
            tick();
            edges++;
        end
        checkOutput("result_arrives", {63'd0, out_valid}, 64'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic doOp(input string tag, input logic sm, input logic [7:0] a,
                        input logic [7:0] b, input logic [15:0] expected);
        int edges;
        applyStimulus(sm, a, b);
        waitResult(edges);
        checkOutput(tag, {48'd0, p}, {48'd0, expected});
        consume();
    endtask

    task automatic doOp32(input string tag, input logic sm, input logic [31:0] a,
                          input logic [31:0] b);
        int                 guard;
        logic [63:0]        ua, ub, expected;
        logic signed [63:0] sa, sb;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        expected = sm ? 64'(sa * sb) : ua * ub;

        signed_mode32 = sm;
        mc32          = a;
        mp32          = b;
        in_valid32    = 1'b1;
        guard         = 0;
        while (!in_ready32 && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        in_valid32 = 1'b0;
        guard      = 0;
        while (!out_valid32 && guard < 300) begin
            tick();
            guard++;
        end
        checkOutput({tag, "_edges"}, 64'(guard), 64'd65);
        checkOutput(tag, p32, expected);
        out_ready32 = 1'b1;
        tick();
        out_ready32 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int   edges;
        logic held;
        logic sawValid;

        rst           = 1'b1;
        in_valid      = 1'b0;
        signed_mode   = 1'b0;
        mc            = '0;
        mp            = '0;
        abort         = 1'b0;
        out_ready     = 1'b0;
        in_valid32    = 1'b0;
        signed_mode32 = 1'b0;
        mc32          = '0;
        mp32          = '0;
        abort32       = 1'b0;
        out_ready32   = 1'b0;

        repeat (2) tick();
        checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_busy",      {63'd0, busy},      64'd0);
        checkOutput("reset_p",         {48'd0, p},         64'd0);
        rst = 1'b0;
        tick();

        // Full-scale unsigned product and accept-to-valid latency.
        applyStimulus(1'b0, 8'hFF, 8'hFF);
        waitResult(edges);
        checkOutput("latency_255x255", 64'(edges), 64'd17);
        checkOutput("p_255x255",       {48'd0, p}, 64'hFE01);
        checkOutput("done_busy",       {63'd0, busy},     64'd0);
        checkOutput("done_in_ready",   {63'd0, in_ready}, 64'd0);
        consume();
        checkOutput("consumed_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("consumed_in_ready",  {63'd0, in_ready},  64'd1);

        doOp("signed_m3x5",      1'b1, 8'hFD, 8'h05, 16'hFFF1);
        doOp("signed_m128xm128", 1'b1, 8'h80, 8'h80, 16'h4000);
        doOp("signed_m128x127",  1'b1, 8'h80, 8'h7F, 16'hC080);
        doOp("unsigned_253x5",   1'b0, 8'hFD, 8'h05, 16'h04F1);

        // Back-to-back: consume of 7*9 coincides with accept of 0*200.
        out_ready   = 1'b1;
        signed_mode = 1'b0;
        mc          = 8'd7;
        mp          = 8'd9;
        in_valid    = 1'b1;
        tick();
        mc = 8'd0;
        mp = 8'd200;
        waitResult(edges);
        checkOutput("b2b_first_latency", 64'(edges), 64'd17);
        checkOutput("b2b_first_p",       {48'd0, p}, 64'd63);
        checkOutput("b2b_in_ready",      {63'd0, in_ready}, 64'd1);
        tick();
        checkOutput("b2b_busy_after",      {63'd0, busy},      64'd1);
        checkOutput("b2b_out_valid_after", {63'd0, out_valid}, 64'd0);
        waitResult(edges);
        checkOutput("b2b_second_latency", 64'(edges), 64'd17);
        checkOutput("b2b_second_p",       {48'd0, p}, 64'd0);
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_drained", {63'd0, out_valid}, 64'd0);

        // Back-pressure: the result must hold for 50 cycles.
        applyStimulus(1'b0, 8'd12, 8'd12);
        waitResult(edges);
        mc       = 8'd1;
        mp       = 8'd1;
        in_valid = 1'b1;
        held     = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            held = held && (p == 16'd144) && out_valid && !in_ready;
        end
        checkOutput("hold_50_cycles", {63'd0, held}, 64'd1);
        checkOutput("hold_p",         {48'd0, p},    64'd144);
        in_valid = 1'b0;
        consume();

        // Abort at cnt=5: five shifts done, p[15:11] = 10000[4:0] = 5'b10000.
        applyStimulus(1'b0, 8'd100, 8'd100);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checkOutput("abort_busy",      {63'd0, busy},      64'd0);
        checkOutput("abort_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("abort_p_kept",    {48'd0, p},         64'h8000);
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            sawValid = sawValid || out_valid;
        end
        checkOutput("abort_no_result", {63'd0, sawValid}, 64'd0);
        doOp("after_abort_3x3", 1'b0, 8'd3, 8'd3, 16'd9);

        // Asynchronous reset in the middle of a run.
        applyStimulus(1'b1, 8'hF0, 8'h22);
        repeat (4) tick();
        rst = 1'b1;
        #2;
        checkOutput("rst_mid_p",         {48'd0, p},         64'd0);
        checkOutput("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("rst_mid_in_ready",  {63'd0, in_ready},  64'd1);
        checkOutput("rst_mid_busy",      {63'd0, busy},      64'd0);
        rst = 1'b0;
        tick();
        doOp("after_rst_13x11", 1'b0, 8'd13, 8'd11, 16'd143);

        // SIZE=32 sweep, corner operands first.
        doOp32("w32_min_x_min", 1'b1, 32'h8000_0000, 32'h8000_0000);
        doOp32("w32_max_u",     1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        doOp32("w32_m1_x_min",  1'b1, 32'hFFFF_FFFF, 32'h8000_0000);
        for (int i = 0; i < 12; i++) begin
            doOp32($sformatf("w32_rand_%0d", i), 1'(i % 2), $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
